// File: rtl/fg_sram_arbiter.sv
// fg_sram_arbiter: single-port SRAM slot arbiter for the foreground buffer.
// Every cycle owns one SRAM slot: pipeline read first, then the capture write
// FIFO head, then the clear fill, otherwise idle. Reads have a fixed latency of 3.
module fg_sram_arbiter #(
    parameter int                    PRECISION    = 11,
    parameter int                    PIXEL_SIZE   = 16,
    parameter int                    ADDR_WIDTH   = 19,
    parameter int                    RESOLUTION_X = 800,
    parameter int                    RESOLUTION_Y = 600,
    parameter int                    WFIFO_DEPTH  = 8,
    parameter logic [PIXEL_SIZE-1:0] CLEAR_PIXEL  = 16'b0010010110001100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_valid,
    input  logic                         rd_active,
    input  logic signed [PRECISION:0]    rd_x,
    input  logic signed [PRECISION:0]    rd_y,
    output logic [PIXEL_SIZE-1:0]        rd_pixel,
    output logic                         rd_skip,
    output logic                         rd_ready,
    input  logic                         wr_valid,
    input  logic [PRECISION-1:0]         wr_x,
    input  logic [PRECISION-1:0]         wr_y,
    input  logic [PIXEL_SIZE-1:0]        wr_pixel,
    output logic                         wr_ready,
    output logic                         wr_overflow,
    input  logic                         clear_start,
    output logic                         clear_busy,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic [PIXEL_SIZE-1:0]        sram_wdata,
    input  logic [PIXEL_SIZE-1:0]        sram_rdata,
    output logic                         sram_we_n,
    output logic                         sram_oe_n
);

    localparam int                    PW        = $clog2(WFIFO_DEPTH);
    localparam logic [PRECISION-1:0]  RES_X_P   = PRECISION'(RESOLUTION_X);
    localparam logic [PRECISION-1:0]  RES_Y_P   = PRECISION'(RESOLUTION_Y);
    localparam logic [ADDR_WIDTH-1:0] RES_X_A   = ADDR_WIDTH'(RESOLUTION_X);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RESOLUTION_X * RESOLUTION_Y - 1);
    localparam logic [PW:0]           DEPTH_C   = (PW + 1)'(WFIFO_DEPTH);

    typedef enum logic {C_IDLE = 1'b0, C_RUN = 1'b1} clr_state_t;

    // Read pipeline: stage 1 = SRAM slot driven, stage 2 = data returning, then response
    logic                    rd_v1_q, rd_v1_d, rd_ok1_q, rd_ok1_d;
    logic                    rd_v2_q, rd_v2_d, rd_ok2_q, rd_ok2_d;
    logic                    rd_ready_q, rd_ready_d, rd_skip_q, rd_skip_d;
    logic [PIXEL_SIZE-1:0]   rd_pixel_q, rd_pixel_d;

    // SRAM port registers
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [PIXEL_SIZE-1:0]   sram_wdata_q, sram_wdata_d;
    logic                    sram_we_n_q, sram_we_n_d, sram_oe_n_q, sram_oe_n_d;

    // Write FIFO: entries hold the precomputed address, pixel and an in-buffer flag
    logic [ADDR_WIDTH-1:0]   fifo_addr_mem [WFIFO_DEPTH];
    logic [PIXEL_SIZE-1:0]   fifo_pix_mem  [WFIFO_DEPTH];
    logic                    fifo_ok_mem   [WFIFO_DEPTH];
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    // Clear fill
    clr_state_t              clr_state_q, clr_state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

    logic                    rd_in_range, grant_rd, grant_wr, grant_clr;
    logic                    wr_in_range, push, pop, fifo_empty;
    logic [ADDR_WIDTH-1:0]   rd_addr, wr_addr;

    // A fetch is only a real read when active and inside the buffer (sign bit clear)
    assign rd_in_range = !rd_x[PRECISION] && !rd_y[PRECISION]
                      && (rd_x[PRECISION-1:0] < RES_X_P) && (rd_y[PRECISION-1:0] < RES_Y_P);
    assign rd_addr     = ADDR_WIDTH'(rd_y[PRECISION-1:0]) * RES_X_A + ADDR_WIDTH'(rd_x[PRECISION-1:0]);
    assign wr_in_range = (wr_x < RES_X_P) && (wr_y < RES_Y_P);
    assign wr_addr     = ADDR_WIDTH'(wr_y) * RES_X_A + ADDR_WIDTH'(wr_x);

    assign fifo_empty  = (cnt_q == '0);
    assign wr_ready    = (cnt_q != DEPTH_C);
    assign push        = wr_valid && wr_ready;

    assign grant_rd    = rd_valid && rd_active && rd_in_range;
    assign grant_wr    = !grant_rd && !fifo_empty;
    assign grant_clr   = !grant_rd && fifo_empty && (clr_state_q == C_RUN);
    assign pop         = grant_wr;

    // Datapath next state: slot outputs, FIFO pointers, read pipeline
    always_comb begin
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        if (grant_rd) begin
            sram_addr_d = rd_addr;
            sram_oe_n_d = 1'b0;
        end else if (grant_wr) begin
            // Out-of-buffer entries burn the slot without touching the SRAM
            if (fifo_ok_mem[rptr_q]) begin
                sram_addr_d  = fifo_addr_mem[rptr_q];
                sram_wdata_d = fifo_pix_mem[rptr_q];
                sram_we_n_d  = 1'b0;
            end
        end else if (grant_clr) begin
            sram_addr_d  = clr_cnt_q;
            sram_wdata_d = CLEAR_PIXEL;
            sram_we_n_d  = 1'b0;
        end

        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        cnt_d  = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        ovf_d  = ovf_q | (wr_valid & ~wr_ready);

        rd_v1_d    = rd_valid;
        rd_ok1_d   = grant_rd;
        rd_v2_d    = rd_v1_q;
        rd_ok2_d   = rd_ok1_q;
        rd_ready_d = rd_v2_q;
        rd_skip_d  = rd_v2_q & ~rd_ok2_q;
        rd_pixel_d = (rd_v2_q && rd_ok2_q) ? sram_rdata : '0;
    end

    // Clear FSM next state: walk every address once, restart requests ignored while running
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        case (clr_state_q)
            C_IDLE: begin
                if (clear_start) begin
                    clr_state_d = C_RUN;
                    clr_cnt_d   = '0;
                end
            end
            C_RUN: begin
                if (grant_clr) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_state_d = C_IDLE;
                        clr_cnt_d   = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: clr_state_d = C_IDLE;
        endcase
    end

    // FIFO storage: plain array, no reset needed on data
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wptr_q] <= wr_addr;
            fifo_pix_mem[wptr_q]  <= wr_pixel;
            fifo_ok_mem[wptr_q]   <= wr_in_range;
        end
    end

    // State registers with synchronous active-low reset (drops in-flight reads and clears)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v1_q      <= 1'b0;
            rd_ok1_q     <= 1'b0;
            rd_v2_q      <= 1'b0;
            rd_ok2_q     <= 1'b0;
            rd_ready_q   <= 1'b0;
            rd_skip_q    <= 1'b0;
            rd_pixel_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            clr_state_q  <= C_IDLE;
            clr_cnt_q    <= '0;
        end else begin
            rd_v1_q      <= rd_v1_d;
            rd_ok1_q     <= rd_ok1_d;
            rd_v2_q      <= rd_v2_d;
            rd_ok2_q     <= rd_ok2_d;
            rd_ready_q   <= rd_ready_d;
            rd_skip_q    <= rd_skip_d;
            rd_pixel_q   <= rd_pixel_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            clr_state_q  <= clr_state_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign rd_ready    = rd_ready_q;
    assign rd_skip     = rd_skip_q;
    assign rd_pixel    = rd_pixel_q;
    assign wr_overflow = ovf_q;
    assign clear_busy  = (clr_state_q == C_RUN);
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_oe_n   = sram_oe_n_q;

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// tb_fg_sram_arbiter: directed + randomized bench with an SRAM model, a
// transaction-level read scoreboard and a shadow copy of the buffer contents.
module tb_fg_sram_arbiter;

    localparam int PREC    = 11;
    localparam int AW      = 19;
    localparam int RX      = 40;
    localparam int RY      = 25;
    localparam int N       = RX * RY;
    localparam int RD_ROWS = 12;   // reads use rows below this, writes rows at/above it
    localparam logic [15:0] CLR = 16'b0010010110001100;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   rd_valid, rd_active;
    logic signed [PREC:0]   rd_x, rd_y;
    logic [15:0]            rd_pixel;
    logic                   rd_skip, rd_ready;
    logic                   wr_valid;
    logic [PREC-1:0]        wr_x, wr_y;
    logic [15:0]            wr_pixel;
    logic                   wr_ready, wr_overflow;
    logic                   clear_start, clear_busy;
    logic [AW-1:0]          sram_addr;
    logic [15:0]            sram_wdata, sram_rdata;
    logic                   sram_we_n, sram_oe_n;

    always #5 clk = ~clk;

    fg_sram_arbiter #(
        .PRECISION(PREC), .PIXEL_SIZE(16), .ADDR_WIDTH(AW),
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .WFIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_active(rd_active), .rd_x(rd_x), .rd_y(rd_y),
        .rd_pixel(rd_pixel), .rd_skip(rd_skip), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .wr_ready(wr_ready), .wr_overflow(wr_overflow),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        logic [31:0] v;
        v = a * 40503 + 4660;
        return (a == 90) ? 16'hF800 : v[15:0];
    endfunction

    function automatic bit rd_ok(input int x, input int y, input logic act);
        return act && x >= 0 && x < RX && y >= 0 && y < RY;
    endfunction

    // SRAM model: write at end of slot cycle, read data valid the cycle after the slot
    logic [15:0] sram_mem [N];
    logic [15:0] ref_mem  [N];
    logic        mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int a = 0; a < N; a++) sram_mem[a] <= init_val(a);
            mem_inited <= 1'b1;
        end else begin
            if (!sram_we_n && sram_addr < AW'(N)) sram_mem[sram_addr] <= sram_wdata;
            if (!sram_oe_n && sram_addr < AW'(N)) sram_rdata <= sram_mem[sram_addr];
        end
    end

    // Read scoreboard: every accepted fetch expects a response exactly 3 cycles later
    typedef struct {
        int          due;
        logic        skip;
        logic [15:0] pix;
    } exp_t;
    exp_t        exp_q[$];
    logic        exp_oe = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] last_w_addr = '0;
    logic [15:0]   last_w_data = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_oe <= 1'b0;
        end else begin
            if (rd_valid)
                exp_q.push_back('{due: cyc + 3,
                                  skip: !rd_ok(int'(rd_x), int'(rd_y), rd_active),
                                  pix: rd_ok(int'(rd_x), int'(rd_y), rd_active)
                                       ? ref_mem[int'(rd_y) * RX + int'(rd_x)] : 16'h0});
            exp_oe   <= rd_valid && rd_ok(int'(rd_x), int'(rd_y), rd_active);
            exp_addr <= AW'(int'(rd_y) * RX + int'(rd_x));
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check_eq("rd_ready", 32'(rd_ready), 32'd1);
                check_eq("rd_skip", 32'(rd_skip), 32'(exp_q[0].skip));
                check_eq("rd_pixel", 32'(rd_pixel), 32'(exp_q[0].pix));
                exp_q.delete(0);
            end else begin
                check_eq("rd_ready_idle", 32'(rd_ready), 32'd0);
            end
            check_eq("sram_oe_n", 32'(sram_oe_n), 32'(!exp_oe));
            if (exp_oe) check_eq("rd_sram_addr", 32'(sram_addr), 32'(exp_addr));
            if (!sram_we_n) begin
                check_eq("we_oe_excl", 32'(sram_oe_n), 32'd1);
                last_w_addr <= sram_addr;
                last_w_data <= sram_wdata;
            end
        end
    end

    // Advance one cycle; a write offered while ready lands in the shadow buffer
    task automatic tick();
        if (rst_n && wr_valid && wr_ready && int'(wr_x) < RX && int'(wr_y) < RY)
            ref_mem[int'(wr_y) * RX + int'(wr_x)] = wr_pixel;
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input bit v, input int x, input int y, input bit act);
        rd_valid  = v;
        rd_active = act;
        rd_x      = (PREC + 1)'(x);
        rd_y      = (PREC + 1)'(y);
    endtask

    task automatic set_write(input bit v, input int x, input int y, input logic [15:0] p);
        wr_valid = v;
        wr_x     = PREC'(x);
        wr_y     = PREC'(y);
        wr_pixel = p;
    endtask

    task automatic compare_mem(input string tag);
        for (int a = 0; a < N; a++) check_eq(tag, 32'(sram_mem[a]), 32'(ref_mem[a]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int sk, wn, busy_n;

    initial begin
        rst_n = 1'b0;
        clear_start = 1'b0;
        set_read(0, 0, 0, 0);
        set_write(0, 0, 0, 16'h0);
        for (int a = 0; a < N; a++) ref_mem[a] = init_val(a);
        repeat (3) tick();
        chk_en = 1'b1;
        tick();

        // Reset state
        check_eq("rst_rd_ready", 32'(rd_ready), 32'd0);
        check_eq("rst_rd_skip", 32'(rd_skip), 32'd0);
        check_eq("rst_rd_pixel", 32'(rd_pixel), 32'd0);
        check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_wdata", 32'(sram_wdata), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_overflow", 32'(wr_overflow), 32'd0);
        check_eq("rst_busy", 32'(clear_busy), 32'd0);
        rst_n = 1'b1;
        tick();
        $display("reset state checked");

        // Directed read at (10,2)
        set_read(1, 10, 2, 1);
        tick();
        check_eq("dir_addr", 32'(sram_addr), 32'(2 * RX + 10));
        check_eq("dir_oe_n", 32'(sram_oe_n), 32'd0);
        set_read(0, 0, 0, 0);
        tick();
        tick();
        check_eq("dir_ready", 32'(rd_ready), 32'd1);
        check_eq("dir_skip", 32'(rd_skip), 32'd0);
        check_eq("dir_pixel", 32'(rd_pixel), 32'hF800);
        $display("directed read x=10 y=2 pixel=%h", rd_pixel);

        // Three skip flavours back to back
        set_read(1, -1, 3, 1); tick();
        set_read(1, 5, RY, 1); tick();
        set_read(1, 5, 3, 0);  tick();
        set_read(0, 0, 0, 0);
        sk = 0;
        for (int k = 0; k < 4; k++) begin
            if (rd_ready && rd_skip) sk++;
            tick();
        end
        check_eq("skip_pulses", 32'(sk), 32'd3);
        $display("skip reads: %0d skip responses", sk);

        // Randomized reads with concurrent capture writes
        for (int i = 0; i < 3000; i++) begin
            set_read($urandom_range(0, 1), $urandom_range(0, RX + 3) - 2,
                     ($urandom_range(0, 7) == 0) ? RY + $urandom_range(0, 2)
                                                 : $urandom_range(0, RD_ROWS + 1) - 2,
                     $urandom_range(0, 7) != 0);
            set_write(wr_ready && ($urandom_range(0, 2) == 0), $urandom_range(0, RX + 2),
                      $urandom_range(RD_ROWS, RY + 1), 16'($urandom));
            tick();
        end
        set_read(0, 0, 0, 0);
        set_write(0, 0, 0, 16'h0);
        repeat (20) tick();
        compare_mem("mem_random");
        check_eq("random_no_ovf", 32'(wr_overflow), 32'd0);
        $display("random phase: 3000 cycles");

        // Contention: 3 queued writes, reads on alternate cycles
        for (int k = 0; k < 3; k++) begin
            set_read(1, k + 1, 2, 1);
            set_write(1, k + 1, RD_ROWS + k, 16'hC000 + 16'(k));
            tick();
        end
        set_write(0, 0, 0, 16'h0);
        wn = 0;
        for (int k = 0; k < 6; k++) begin
            set_read(k % 2 == 0, 7, 3, 1);
            tick();
            if (!sram_we_n) wn++;
        end
        set_read(0, 0, 0, 0);
        check_eq("contention_writes", 32'(wn), 32'd3);
        repeat (5) tick();
        $display("contention: %0d writes in 6 cycles", wn);

        // Overflow: 9 pushes while reads hold every slot
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int k = 0; k < 9; k++) begin
            set_read(1, 3, 4, 1);
            set_write(1, (k == 8) ? 20 : k, RD_ROWS + 3, 16'hA000 + 16'(k));
            tick();
            check_eq("ovf_wr_ready", 32'(wr_ready), (k < 7) ? 32'd1 : 32'd0);
            check_eq("ovf_flag", 32'(wr_overflow), (k == 8) ? 32'd1 : 32'd0);
        end
        set_write(0, 0, 0, 16'h0);
        repeat (3) tick();
        check_eq("ovf_full_hold", 32'(wr_ready), 32'd0);
        check_eq("ovf_sticky1", 32'(wr_overflow), 32'd1);
        set_read(0, 0, 0, 0);
        repeat (15) tick();
        check_eq("ovf_drained", 32'(wr_ready), 32'd1);
        check_eq("ovf_sticky2", 32'(wr_overflow), 32'd1);
        compare_mem("mem_overflow");
        $display("overflow: 9 offered, overflow=%0b", wr_overflow);

        // Clear with a mid-run restart request
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (clear_busy) busy_n++;
            else break;
            clear_start = (i == N / 3);
            tick();
        end
        clear_start = 1'b0;
        tick(); tick();
        check_eq("clear_busy_cycles", 32'(busy_n), 32'(N));
        check_eq("clear_last_addr", 32'(last_w_addr), 32'(N - 1));
        check_eq("clear_last_data", 32'(last_w_data), 32'(CLR));
        for (int a = 0; a < N; a++) ref_mem[a] = CLR;
        compare_mem("mem_clear");
        $display("clear: busy %0d cycles", busy_n);

        // Clear with a capture write behind the fill front
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        for (int i = 0; i < 3 * N; i++) begin
            if (!clear_busy) break;
            set_write(i == 100, 5, 0, 16'h1234);
            tick();
        end
        set_write(0, 0, 0, 16'h0);
        tick(); tick();
        check_eq("clear2_done", 32'(clear_busy), 32'd0);
        compare_mem("mem_clear_write");
        $display("clear with write at address 5");

        // Reset during clear and reads
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_read(1, 10 + k, 1, 1);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_read(0, 0, 0, 0);
        check_eq("rst2_busy", 32'(clear_busy), 32'd0);
        check_eq("rst2_ready", 32'(rd_ready), 32'd0);
        check_eq("rst2_addr", 32'(sram_addr), 32'd0);
        tick();
        set_read(1, 12, 3, 1);
        tick();
        set_read(0, 0, 0, 0);
        tick();
        tick();
        check_eq("post_rst_ready", 32'(rd_ready), 32'd1);
        check_eq("post_rst_pixel", 32'(rd_pixel), 32'(CLR));
        repeat (5) tick();
        check_eq("post_rst_busy", 32'(clear_busy), 32'd0);
        $display("reset during clear and reads");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
